// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity mode codes and the
// baud divisor helper. Used by uart_tx_frame and the planned uart_rx_frame.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Clocks per bit, rounded to nearest.
   function automatic int calc_div(input int clk_freq, input int baud_rate);
      return (clk_freq + baud_rate / 2) / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..DIV-1 while enabled, pulses tick on DIV-1 and
// wraps, so every bit lasts exactly DIV clocks. Held at 0 while disabled.
module uart_baud_tick #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // Free-run while enabled; clear on reset, disable or wrap.
   always_ff @(posedge clk) begin
      if (rst || !en || tick) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter, one character per valid/ready handshake.
// Frame: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stops.
// Build option: define UART_TX_PARITY_EN to include the parity bit
// (PARITY_MODE 1 odd, 2 even, 0 none); without it frames never carry parity.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int BAUD_RATE   = 9600,
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 1,
   parameter int PARITY_MODE = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 uart_tx
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
   localparam int CW  = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_frame: CLK_FREQ/BAUD_RATE gives DIV < 2");
   end
   if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
   end

   uart_state_t          state, state_nxt;
   logic [DATA_BITS-1:0] shift, shift_nxt;
   logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
   logic                 line_nxt, done_nxt;
   logic                 tick, accept, baud_en;

   assign tx_ready = (state == ST_IDLE);
   assign accept   = tx_valid && tx_ready;
   assign baud_en  = (state != ST_IDLE);

   uart_baud_tick #(.DIV(DIV)) u_baud (
      .clk  (clk),
      .rst  (rst),
      .en   (baud_en),
      .tick (tick)
   );

`ifdef UART_TX_PARITY_EN
   localparam bit USE_PAR = (PARITY_MODE != PARITY_NONE);
   logic par_bit;

   // Parity is taken from the character as latched, not the live bus.
   always_ff @(posedge clk) begin
      if (rst)         par_bit <= 1'b0;
      else if (accept) par_bit <= (PARITY_MODE == PARITY_ODD) ? ~^tx_data : ^tx_data;
   end
`endif

   // Next state, shifter and bit counter; line value derived from next state
   // so uart_tx is a clean register.
   always_comb begin
      state_nxt   = state;
      shift_nxt   = shift;
      bit_cnt_nxt = bit_cnt;
      done_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_START;
               shift_nxt = tx_data;
            end
         end
         ST_START: begin
            if (tick) begin
               state_nxt   = ST_DATA;
               bit_cnt_nxt = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_cnt == LAST_DATA) begin
                  bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  state_nxt   = USE_PAR ? ST_PARITY : ST_STOP;
`else
                  state_nxt   = ST_STOP;
`endif
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
                  shift_nxt   = shift >> 1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               state_nxt   = ST_STOP;
               bit_cnt_nxt = '0;
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (bit_cnt == LAST_STOP) begin
                  state_nxt   = ST_IDLE;
                  bit_cnt_nxt = '0;
                  done_nxt    = 1'b1;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      case (state_nxt)
         ST_START:  line_nxt = 1'b0;
         ST_DATA:   line_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: line_nxt = par_bit;
`endif
         default:   line_nxt = 1'b1;
      endcase
   end

   // State and registered outputs; reset aborts any frame with line high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         shift   <= '0;
         bit_cnt <= '0;
         uart_tx <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         state   <= state_nxt;
         shift   <= shift_nxt;
         bit_cnt <= bit_cnt_nxt;
         uart_tx <= line_nxt;
         tx_busy <= (state_nxt != ST_IDLE);
         tx_done <= done_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: two instances (8 data/1 stop,
// 7 data/2 stop) at DIV=10, a frame-level reference model, directed literal
// checks and randomized traffic. Honours UART_TX_PARITY_EN like the DUT.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int DIV = 10;
   localparam int L   = DIV * (10 + P);   // both instances: 1+8+P+1 and 1+7+P+2

   localparam logic [10:0] LIT_A5 = P ? 11'b10101001010 : 11'b01101001010;
   localparam logic [10:0] LIT_41 = P ? 11'b11110000010 : 11'b01110000010;
   localparam logic [10:0] LIT_0F = P ? 11'b10000011110 : 11'b01000011110;

   logic clk = 1'b0, rst = 1'b1;
   logic v0 = 1'b0, v1 = 1'b0;
   logic [7:0] d0 = '0;
   logic [6:0] d1 = '0;
   logic rdy0, busy0, done0, line0, rdy1, busy1, done1, line1;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                   .STOP_BITS(1), .PARITY_MODE(2)) dut0 (
      .clk(clk), .rst(rst), .tx_valid(v0), .tx_data(d0),
      .tx_ready(rdy0), .tx_busy(busy0), .tx_done(done0), .uart_tx(line0));

   uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                   .STOP_BITS(2), .PARITY_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(d1),
      .tx_ready(rdy1), .tx_busy(busy1), .tx_done(done1), .uart_tx(line1));

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int n_bits(input int i);
      return (i == 0) ? (1 + 8 + P + 1) : (1 + 7 + P + 2);
   endfunction

   // Line sequence for one character, element k = bit period k.
   function automatic logic [15:0] frame_bits(input int i, input logic [8:0] d);
      logic [15:0] f;
      int db, pm, ones, k;
      db = (i == 0) ? 8 : 7;
      pm = (i == 0) ? 2 : 1;
      f = '1;
      f[0] = 1'b0;
      ones = 0;
      for (int b = 0; b < db; b++) begin
         f[1 + b] = d[b];
         ones += int'(d[b]);
      end
      k = 1 + db;
      if (P == 1) f[k] = (pm == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      return f;
   endfunction

   int          pos  [2] = '{-1, -1};
   logic [15:0] fb   [2];
   logic        edone[2] = '{1'b0, 1'b0};
   bit          mdl_ok = 1'b0;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         edone[i] = 1'b0;
         if (rst) pos[i] = -1;
         else if (pos[i] < 0) begin
            if (i == 0 ? v0 : v1) begin
               fb[i]  = frame_bits(i, (i == 0) ? {1'b0, d0} : {2'b0, d1});
               pos[i] = 0;
            end
         end else begin
            pos[i]++;
            if (pos[i] == DIV * n_bits(i)) begin
               pos[i]   = -1;
               edone[i] = 1'b1;
            end
         end
      end
      if (rst) mdl_ok = 1'b1;
   end

   // Every cycle: outputs against the model.
   always @(negedge clk) begin
      if (mdl_ok) begin
         for (int i = 0; i < 2; i++) begin
            logic el;
            el = (pos[i] < 0) ? 1'b1 : fb[i][pos[i] / DIV];
            chk1($sformatf("line%0d", i),  (i == 0) ? line0 : line1, el);
            chk1($sformatf("busy%0d", i),  (i == 0) ? busy0 : busy1, pos[i] >= 0);
            chk1($sformatf("ready%0d", i), (i == 0) ? rdy0 : rdy1, pos[i] < 0);
            chk1($sformatf("done%0d", i),  (i == 0) ? done0 : done1, edone[i]);
         end
      end
   end

   // ---------------- directed stimulus helpers ----------------
   logic log0[0:299], log1[0:299];
   int   dc0, dc1, nrdy1;

   // Send one character on each instance, log the line for ncyc cycles
   // after the accept edge while scrambling tx_data every clock.
   task automatic send_log(input logic [7:0] a, input logic [6:0] b, input int ncyc);
      @(negedge clk); v0 = 1'b1; d0 = a; v1 = 1'b1; d1 = b;
      @(posedge clk);
      dc0 = -1; dc1 = -1; nrdy1 = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         v0 = 1'b0; v1 = 1'b0;
         d0 = 8'($urandom); d1 = 7'($urandom);
         log0[c] = line0; log1[c] = line1;
         if (done0 && dc0 < 0) dc0 = c;
         if (done1 && dc1 < 0) dc1 = c;
         if (c < L && rdy1) nrdy1++;
      end
   endtask

   task automatic chk_frame(input string nm, input int i, input logic [10:0] lit);
      for (int k = 0; k < 10 + P; k++)
         chk1($sformatf("%s_bit%0d", nm, k), (i == 0) ? log0[DIV*k+5] : log1[DIV*k+5], lit[k]);
   endtask

   initial begin
      logic [15:0] mb;
      int nd;

      // Model pinned to hand-derived frames.
      mb = frame_bits(0, 9'h0A5);
      for (int k = 0; k < 10 + P; k++) chk1($sformatf("model_a5_%0d", k), mb[k], LIT_A5[k]);
      mb = frame_bits(1, 9'h041);
      for (int k = 0; k < 10 + P; k++) chk1($sformatf("model_41_%0d", k), mb[k], LIT_41[k]);

      // Reset state.
      repeat (3) @(negedge clk);
      chk1("rst_line", line0, 1'b1);
      chk1("rst_busy", busy0, 1'b0);
      chk1("rst_done", done0, 1'b0);
      rst = 1'b0;
      #1 chk1("ready_after_rst", rdy0, 1'b1);

      // 0xA5 on 8N1 (+parity), 0x41 on 7-bit/2-stop.
      send_log(8'hA5, 7'h41, L + 10);
      chk_frame("a5", 0, LIT_A5);
      chk_frame("x41", 1, LIT_41);
      chki("a5_done_lat", dc0, L);
      chki("x41_done_lat", dc1, L);
      chki("x41_ready_low", nrdy1, 0);

      // Back-to-back 0x55 then 0xAA with tx_valid held.
      @(negedge clk); v0 = 1'b1; d0 = 8'h55;
      @(posedge clk);
      nd = 0; dc0 = -1; dc1 = -1;
      for (int c = 0; c < 2 * L + 20; c++) begin
         @(negedge clk);
         d0 = 8'hAA;
         if (busy0 && c > L) v0 = 1'b0;
         log0[c] = line0;
         if (done0) begin
            if (nd == 0) dc0 = c; else if (nd == 1) dc1 = c;
            nd++;
         end
      end
      v0 = 1'b0;
      chki("b2b_dones", nd, 2);
      chki("b2b_done1", dc0, L);
      chki("b2b_done2", dc1, 2 * L + 1);
      chk1("b2b_gap", log0[L], 1'b1);
      chk1("b2b_start2", log0[L + 1], 1'b0);

      // Reset 35 clocks into a frame, then a clean 0x0F frame.
      @(negedge clk); v0 = 1'b1; d0 = 8'hC3; v1 = 1'b1; d1 = 7'h2C;
      @(posedge clk);
      for (int c = 0; c < 34; c++) begin
         @(negedge clk); v0 = 1'b0; v1 = 1'b0;
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk1("abort_line", line0, 1'b1);
      chk1("abort_busy", busy0, 1'b0);
      rst = 1'b0;
      nd = 0;
      for (int c = 0; c < 150; c++) begin
         @(negedge clk);
         if (done0) nd++;
      end
      chki("abort_no_done", nd, 0);
      send_log(8'h0F, 7'h33, L + 10);
      chk_frame("x0f", 0, LIT_0F);
      chki("x0f_done_lat", dc0, L);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         v0  = ($urandom_range(0, 3) != 0);
         v1  = ($urandom_range(0, 3) != 0);
         d0  = 8'($urandom);
         d1  = 7'($urandom);
         rst = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk); rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
      repeat (2 * L) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
